// File: rtl/zone_alarm_encoder.sv
// Zone alarm encoder: latches multi-hot zone alarms and offers one 2-bit zone ID at a time.
// Latency: alarm sampled at edge N is pending at N, offered (out_valid) after edge N+1.
// Backpressure: out_zone/out_valid held while out_ready=0; max one dispatch per two clocks.
// Optional feature: define ROUND_ROBIN_EN for rotating-priority selection (default: lowest index wins).
module zone_alarm_encoder #(
    parameter int NZONES = 4,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NZONES-1:0] alarm_in,
    input  logic              out_ready,
    input  logic              clr_cnt,
    output logic              out_valid,
    output logic [ID_W-1:0]   out_zone,
    output logic [NZONES-1:0] pending,
    output logic [ID_W:0]     pending_cnt,
    output logic              busy,
    output logic [CNT_W-1:0]  dispatch_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [ID_W-1:0]   out_zone_q, out_zone_d;
    logic [NZONES-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   sel_zone;
    logic [NZONES-1:0] clr_mask;
    logic [ID_W:0]     pcnt;
    logic              hs;

`ifdef ROUND_ROBIN_EN
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   cand;
    logic              found;

    // Rotating priority: first pending zone at or after rr_ptr, wrapping past the top zone.
    always_comb begin
        sel_zone = '0;
        cand     = '0;
        found    = 1'b0;
        for (int k = 0; k < NZONES; k++) begin
            cand = rr_ptr_q + ID_W'(k);
            if (!found && pending_q[cand]) begin
                sel_zone = cand;
                found    = 1'b1;
            end
        end
    end

    // Pointer moves just past the zone that was dispatched, so a held zone cannot starve others.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = out_zone_q + ID_W'(1);
        end
    end
`else
    // Fixed priority: lowest-index pending zone wins (scan downwards, last hit is lowest).
    always_comb begin
        sel_zone = '0;
        for (int i = NZONES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_zone = ID_W'(i);
            end
        end
    end
`endif

    assign hs = (state_q == OFFER) && out_valid_q && out_ready;

    // Offer FSM: load a zone from IDLE, hold it stable in OFFER until the handshake.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_zone_d  = out_zone_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    out_zone_d  = sel_zone;
                    out_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (hs) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Pending latch: handshake clears the offered zone, a new alarm in the same cycle re-sets it.
    always_comb begin
        clr_mask = '0;
        if (hs) begin
            clr_mask[out_zone_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | alarm_in;
    end

    // Dispatch counter: clear has priority over a handshake; saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hs && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Population count of the pending register.
    always_comb begin
        pcnt = '0;
        for (int i = 0; i < NZONES; i++) begin
            pcnt = pcnt + (ID_W+1)'(pending_q[i]);
        end
    end

    // State registers; asynchronous reset drops out_valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_zone_q  <= '0;
            pending_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_zone_q  <= out_zone_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef ROUND_ROBIN_EN
    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign out_valid    = out_valid_q;
    assign out_zone     = out_zone_q;
    assign pending      = pending_q;
    assign pending_cnt  = pcnt;
    assign busy         = |pending_q;
    assign dispatch_cnt = cnt_q;

endmodule

// File: tb/tb_zone_alarm_encoder.sv
// Self-checking bench for zone_alarm_encoder: cycle model plus directed literal checks.
// Inputs change just after the falling edge; outputs are checked on the falling edge.
module tb_zone_alarm_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] alarm_in;
    logic       out_ready;
    logic       clr_cnt;
    logic       out_valid;
    logic [1:0] out_zone;
    logic [3:0] pending;
    logic [2:0] pending_cnt;
    logic       busy;
    logic [7:0] dispatch_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zone_alarm_encoder #(.NZONES(4), .ID_W(2), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alarm_in    (alarm_in),
        .out_ready   (out_ready),
        .clr_cnt     (clr_cnt),
        .out_valid   (out_valid),
        .out_zone    (out_zone),
        .pending     (pending),
        .pending_cnt (pending_cnt),
        .busy        (busy),
        .dispatch_cnt(dispatch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: set of pending zones, current offer, dispatch tally.
    bit [3:0] m_pend;
    bit       m_valid;
    int       m_zone;
    int       m_cnt;
    int       m_rr;
    bit       m_hs;
    bit       m_picked;
    bit [3:0] m_next;
    int       m_start;
    int       m_z;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend = '0; m_valid = 0; m_zone = 0; m_cnt = 0; m_rr = 0;
        end else begin
            m_hs   = m_valid && out_ready;
            m_next = m_pend;
            if (m_hs) m_next[m_zone] = 1'b0;
            m_next = m_next | alarm_in;
            if (clr_cnt) m_cnt = 0;
            else if (m_hs && m_cnt < 255) m_cnt = m_cnt + 1;
            if (m_hs) begin
                m_valid = 0;
                m_rr    = (m_zone + 1) % 4;
            end else if (!m_valid && m_pend != 0) begin
`ifdef ROUND_ROBIN_EN
                m_start = m_rr;
`else
                m_start = 0;
`endif
                m_picked = 0;
                for (int k = 0; k < 4; k++) begin
                    m_z = (m_start + k) % 4;
                    if (!m_picked && m_pend[m_z]) begin
                        m_zone   = m_z;
                        m_picked = 1;
                    end
                end
                m_valid = 1;
            end
            m_pend = m_next;
        end
    end

    // Every-cycle comparison against the model (all zeros while reset is held).
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_pending", pending, 0);
            chk("rst_cnt", dispatch_cnt, 0);
            chk("rst_zone", out_zone, 0);
        end else begin
            chk("m_valid", out_valid, m_valid);
            chk("m_zone", out_zone, m_zone[1:0]);
            chk("m_pending", pending, m_pend);
            chk("m_pcnt", pending_cnt, $countones(m_pend));
            chk("m_busy", busy, m_pend != 0);
            chk("m_cnt", dispatch_cnt, m_cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int zones[$];
    int exp_seq[5];
    int n;
    int first_z, second_z;

    initial begin
        rst_n = 0; alarm_in = '0; out_ready = 0; clr_cnt = 0;
        step(2);
        chk("init_valid", out_valid, 0);
        chk("init_pending", pending, 0);
        chk("init_cnt", dispatch_cnt, 0);
        rst_n = 1;
        step(1);

        // Single alarm on zone 2
        alarm_in = 4'b0100; out_ready = 1;
        step(1);
        alarm_in = '0;
        chk("single_pend", pending, 4'b0100);
        chk("single_notyet", out_valid, 0);
        chk("single_pcnt", pending_cnt, 1);
        step(1);
        chk("single_valid", out_valid, 1);
        chk("single_zone", out_zone, 2);
        step(1);
        chk("single_done_valid", out_valid, 0);
        chk("single_done_pend", pending, 0);
        chk("single_done_cnt", dispatch_cnt, 1);

        // Backpressure with zones 0 and 3
`ifdef ROUND_ROBIN_EN
        first_z = 3; second_z = 0;
`else
        first_z = 0; second_z = 3;
`endif
        clr_cnt = 1; out_ready = 0; alarm_in = 4'b1001;
        step(1);
        clr_cnt = 0; alarm_in = '0;
        chk("bp_clr_cnt", dispatch_cnt, 0);
        chk("bp_pcnt", pending_cnt, 2);
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_zone", out_zone, first_z);
            step(1);
        end
        out_ready = 1;
        step(1);
        chk("bp_hs1_valid", out_valid, 0);
        chk("bp_hs1_pend", pending, 4'b1001 & ~(4'b0001 << first_z));
        step(1);
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_zone", out_zone, second_z);
        step(1);
        chk("bp_cnt", dispatch_cnt, 2);
        chk("bp_pend_empty", pending, 0);

        // Set and clear of zone 1 in the same cycle
        alarm_in = 4'b0010;
        step(2);
        chk("sc_valid", out_valid, 1);
        chk("sc_zone", out_zone, 1);
        step(1);
        chk("sc_pend_kept", pending, 4'b0010);
        chk("sc_bubble", out_valid, 0);
        chk("sc_cnt", dispatch_cnt, 3);
        step(1);
        chk("sc_reoffer_valid", out_valid, 1);
        chk("sc_reoffer_zone", out_zone, 1);
        alarm_in = '0;
        step(1);
        chk("sc_drained", pending, 0);
        chk("sc_cnt2", dispatch_cnt, 4);

        // Saturation then clear coinciding with a handshake
        alarm_in = 4'b0001;
        step(540);
        chk("sat_cnt", dispatch_cnt, 255);
        n = 0;
        while (!out_valid && n < 4) begin step(1); n++; end
        chk("sat_wait_valid", out_valid, 1);
        clr_cnt = 1;
        step(1);
        clr_cnt = 0; alarm_in = '0;
        chk("clr_wins", dispatch_cnt, 0);
        chk("clr_hs_done", out_valid, 0);
        n = 0;
        while ((busy || out_valid) && n < 20) begin step(1); n++; end
        chk("drain_timeout", busy | out_valid, 0);

        // Asynchronous reset in the middle of an offer
        alarm_in = 4'b0110; out_ready = 0;
        step(1);
        alarm_in = '0;
        step(1);
        chk("mid_offer_valid", out_valid, 1);
        chk("mid_offer_pend", pending, 4'b0110);
        #2 rst_n = 0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_pending", pending, 0);
        chk("async_cnt", dispatch_cnt, 0);
        step(2);
        rst_n = 1;
        step(1);
        chk("post_rst_idle", out_valid, 0);

        // Arbitration with every zone held
`ifdef ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        alarm_in = 4'b1111; out_ready = 1;
        n = 0;
        while (zones.size() < 5 && n < 30) begin
            step(1);
            n++;
            if (out_valid) zones.push_back(int'(out_zone));
        end
        chk("arb_count", zones.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < zones.size()) chk("arb_seq", zones[i], exp_seq[i]);
        end
        alarm_in = '0;
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
